// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - EX operand forwarding select and multi-cycle load-use stall control.
// Defining HAZARD_PERF_CNT_EN adds the StallCycles counter and port.
module hazard_forward_ctrl #(
   parameter int REG_BITS = 5,
   parameter int ZERO_REG = 31,
   parameter int LOAD_LAT = 1,
   parameter int CNT_BITS = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [REG_BITS-1:0] ID_Rn,
   input  logic [REG_BITS-1:0] ID_Rm,
   input  logic                ID_UseRn,
   input  logic                ID_UseRm,
   input  logic [REG_BITS-1:0] EX_Rn,
   input  logic [REG_BITS-1:0] EX_Rm,
   input  logic [REG_BITS-1:0] EX_Rd,
   input  logic                EX_MemRead,
   input  logic [REG_BITS-1:0] MEM_Rd,
   input  logic                MEM_RegWrite,
   input  logic [REG_BITS-1:0] WB_Rd,
   input  logic                WB_RegWrite,
   input  logic                Flush,
   output logic [1:0]          ForwardA,
   output logic [1:0]          ForwardB,
   output logic                Stall,
   output logic                Bubble
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_BITS-1:0] StallCycles
`endif
);

   localparam logic [REG_BITS-1:0] ZERO      = REG_BITS'(ZERO_REG);
   localparam logic [3:0]          HOLD_INIT = 4'(LOAD_LAT - 1);
   localparam bit                  MULTI     = (LOAD_LAT > 1);

   if (LOAD_LAT < 1 || LOAD_LAT > 15 || CNT_BITS < 1) begin : g_bad_param
      $error("hazard_forward_ctrl: LOAD_LAT must be 1..15 and CNT_BITS >= 1");
   end

   typedef enum logic {IDLE, HOLD} state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       haz;
   logic       stall;

   function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] src,
                                          input logic [REG_BITS-1:0] mem_rd,
                                          input logic                mem_we,
                                          input logic [REG_BITS-1:0] wb_rd,
                                          input logic                wb_we);
      logic mem_hit;
      logic wb_hit;
      mem_hit = mem_we && (mem_rd != ZERO) && (mem_rd == src);
      wb_hit  = wb_we && (wb_rd != ZERO) && (wb_rd == src);
      if (mem_hit)     return 2'b10;
      else if (wb_hit) return 2'b01;
      else             return 2'b00;
   endfunction

   always_comb begin
      ForwardA = fwd_sel(EX_Rn, MEM_Rd, MEM_RegWrite, WB_Rd, WB_RegWrite);
      ForwardB = fwd_sel(EX_Rm, MEM_Rd, MEM_RegWrite, WB_Rd, WB_RegWrite);
   end

   always_comb begin
      haz = EX_MemRead && (EX_Rd != ZERO) &&
            ((ID_UseRn && (EX_Rd == ID_Rn)) || (ID_UseRm && (EX_Rd == ID_Rm)));
   end

   // Flush overrides everything: no stall this cycle and any remaining bubbles are dropped.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall   = 1'b0;
      if (Flush) begin
         state_d = IDLE;
         cnt_d   = 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (haz) begin
                  stall = 1'b1;
                  if (MULTI) begin
                     state_d = HOLD;
                     cnt_d   = HOLD_INIT;
                  end
               end
            end
            HOLD: begin
               stall = 1'b1;
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign Stall  = stall;
   assign Bubble = stall;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_BITS-1:0] stall_cycles_q, stall_cycles_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q + CNT_BITS'(stall);
   end

   always_ff @(posedge clk) begin
      if (reset) stall_cycles_q <= '0;
      else       stall_cycles_q <= stall_cycles_d;
   end

   assign StallCycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - directed and random checks of hazard_forward_ctrl.
// Runs a LOAD_LAT=1 and a LOAD_LAT=3 instance side by side; honours HAZARD_PERF_CNT_EN.
module tb_hazard_forward_ctrl;

   logic       clk;
   logic       reset;
   logic [4:0] ID_Rn, ID_Rm, EX_Rn, EX_Rm, EX_Rd, MEM_Rd, WB_Rd;
   logic       ID_UseRn, ID_UseRm, EX_MemRead, MEM_RegWrite, WB_RegWrite, Flush;
   logic [1:0] fa1, fb1, fa3, fb3;
   logic       st1, bu1, st3, bu3;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] sc1, sc3;
`endif

   int pass_cnt = 0;
   int total_cnt = 0;

   hazard_forward_ctrl #(.LOAD_LAT(1)) u_lat1 (
      .clk(clk), .reset(reset),
      .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_UseRn(ID_UseRn), .ID_UseRm(ID_UseRm),
      .EX_Rn(EX_Rn), .EX_Rm(EX_Rm), .EX_Rd(EX_Rd), .EX_MemRead(EX_MemRead),
      .MEM_Rd(MEM_Rd), .MEM_RegWrite(MEM_RegWrite),
      .WB_Rd(WB_Rd), .WB_RegWrite(WB_RegWrite), .Flush(Flush),
      .ForwardA(fa1), .ForwardB(fb1), .Stall(st1), .Bubble(bu1)
`ifdef HAZARD_PERF_CNT_EN
      , .StallCycles(sc1)
`endif
   );

   hazard_forward_ctrl #(.LOAD_LAT(3)) u_lat3 (
      .clk(clk), .reset(reset),
      .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_UseRn(ID_UseRn), .ID_UseRm(ID_UseRm),
      .EX_Rn(EX_Rn), .EX_Rm(EX_Rm), .EX_Rd(EX_Rd), .EX_MemRead(EX_MemRead),
      .MEM_Rd(MEM_Rd), .MEM_RegWrite(MEM_RegWrite),
      .WB_Rd(WB_Rd), .WB_RegWrite(WB_RegWrite), .Flush(Flush),
      .ForwardA(fa3), .ForwardB(fb3), .Stall(st3), .Bubble(bu3)
`ifdef HAZARD_PERF_CNT_EN
      , .StallCycles(sc3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #2;
   endtask

   task automatic clear_inputs;
      ID_Rn = 5'd0; ID_Rm = 5'd0; ID_UseRn = 1'b0; ID_UseRm = 1'b0;
      EX_Rn = 5'd0; EX_Rm = 5'd0; EX_Rd = 5'd0; EX_MemRead = 1'b0;
      MEM_Rd = 5'd0; MEM_RegWrite = 1'b0; WB_Rd = 5'd0; WB_RegWrite = 1'b0;
      Flush = 1'b0;
   endtask

   task automatic do_reset;
      clear_inputs();
      reset = 1'b1;
      next_cycle();
      next_cycle();
      reset = 1'b0;
   endtask

   task automatic load_use_hazard;
      EX_MemRead = 1'b1; EX_Rd = 5'd5; ID_Rm = 5'd5; ID_UseRm = 1'b1;
   endtask

   task automatic test_reset;
      do_reset();
      settle();
      total_cnt++;
      if ({st1, bu1, st3, bu3} !== 4'b0000)
         $display("FAIL reset_stall: got %b want 0000", {st1, bu1, st3, bu3});
      else pass_cnt++;
      total_cnt++;
      if ({fa1, fb1} !== 4'b0000)
         $display("FAIL reset_fwd: got %b want 0000", {fa1, fb1});
      else pass_cnt++;
`ifdef HAZARD_PERF_CNT_EN
      total_cnt++;
      if (sc1 !== 32'd0 || sc3 !== 32'd0)
         $display("FAIL reset_cnt: got %0d/%0d want 0/0", sc1, sc3);
      else pass_cnt++;
`endif
   endtask

   task automatic test_forward_priority;
      clear_inputs();
      EX_Rn = 5'd3; MEM_Rd = 5'd3; WB_Rd = 5'd3; MEM_RegWrite = 1'b1; WB_RegWrite = 1'b1;
      settle();
      total_cnt++;
      if (fa1 !== 2'b10) $display("FAIL fwd_both: got %b want 10", fa1);
      else pass_cnt++;
      MEM_RegWrite = 1'b0;
      settle();
      total_cnt++;
      if (fa1 !== 2'b01) $display("FAIL fwd_wb_only: got %b want 01", fa1);
      else pass_cnt++;
      WB_RegWrite = 1'b0;
      settle();
      total_cnt++;
      if (fa1 !== 2'b00) $display("FAIL fwd_none: got %b want 00", fa1);
      else pass_cnt++;
      MEM_RegWrite = 1'b1; WB_RegWrite = 1'b1; WB_Rd = 5'd7; EX_Rm = 5'd7;
      settle();
      total_cnt++;
      if ({fa3, fb3} !== 4'b1001) $display("FAIL fwd_split: got %b want 1001", {fa3, fb3});
      else pass_cnt++;
   endtask

   task automatic test_zero_reg;
      clear_inputs();
      EX_Rm = 5'd31; MEM_Rd = 5'd31; MEM_RegWrite = 1'b1;
      settle();
      total_cnt++;
      if (fb1 !== 2'b00) $display("FAIL zero_mem: got %b want 00", fb1);
      else pass_cnt++;
      MEM_RegWrite = 1'b0; WB_Rd = 5'd31; WB_RegWrite = 1'b1;
      settle();
      total_cnt++;
      if (fb1 !== 2'b00) $display("FAIL zero_wb: got %b want 00", fb1);
      else pass_cnt++;
   endtask

   task automatic test_load_use_lat1;
      do_reset();
      load_use_hazard();
      settle();
      total_cnt++;
      if ({st1, bu1} !== 2'b11) $display("FAIL lat1_stall: got %b want 11", {st1, bu1});
      else pass_cnt++;
      next_cycle();
      EX_MemRead = 1'b0;
      settle();
      total_cnt++;
      if ({st1, bu1} !== 2'b00) $display("FAIL lat1_release: got %b want 00", {st1, bu1});
      else pass_cnt++;
      load_use_hazard();
      ID_UseRm = 1'b0;
      settle();
      total_cnt++;
      if (st1 !== 1'b0) $display("FAIL lat1_unused: got %b want 0", st1);
      else pass_cnt++;
      clear_inputs();
      EX_MemRead = 1'b1; EX_Rd = 5'd31; ID_Rn = 5'd31; ID_UseRn = 1'b1;
      settle();
      total_cnt++;
      if (st1 !== 1'b0) $display("FAIL lat1_zero_reg: got %b want 0", st1);
      else pass_cnt++;
      clear_inputs();
      load_use_hazard();
      Flush = 1'b1;
      settle();
      total_cnt++;
      if ({st1, bu1} !== 2'b00) $display("FAIL lat1_flush: got %b want 00", {st1, bu1});
      else pass_cnt++;
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_load_use_lat3;
      do_reset();
      load_use_hazard();
      settle();
      total_cnt++;
      if ({st3, bu3} !== 2'b11) $display("FAIL lat3_t0: got %b want 11", {st3, bu3});
      else pass_cnt++;
      next_cycle();
      settle();
      total_cnt++;
      if ({st3, bu3} !== 2'b11) $display("FAIL lat3_t1: got %b want 11", {st3, bu3});
      else pass_cnt++;
      next_cycle();
      settle();
      total_cnt++;
      if ({st3, bu3} !== 2'b11) $display("FAIL lat3_t2: got %b want 11", {st3, bu3});
      else pass_cnt++;
      next_cycle();
      EX_MemRead = 1'b0;
      settle();
      total_cnt++;
      if ({st3, bu3} !== 2'b00) $display("FAIL lat3_t3: got %b want 00", {st3, bu3});
      else pass_cnt++;
`ifdef HAZARD_PERF_CNT_EN
      total_cnt++;
      if (sc3 !== 32'd3) $display("FAIL lat3_cnt: got %0d want 3", sc3);
      else pass_cnt++;
`endif
      next_cycle();
   endtask

   task automatic test_flush_and_reset_in_hold;
      do_reset();
      load_use_hazard();
      next_cycle();
      EX_MemRead = 1'b0;
      Flush = 1'b1;
      settle();
      total_cnt++;
      if ({st3, bu3} !== 2'b00) $display("FAIL flush_t1: got %b want 00", {st3, bu3});
      else pass_cnt++;
      next_cycle();
      Flush = 1'b0;
      settle();
      total_cnt++;
      if (st3 !== 1'b0) $display("FAIL flush_t2: got %b want 0", st3);
      else pass_cnt++;
`ifdef HAZARD_PERF_CNT_EN
      total_cnt++;
      if (sc3 !== 32'd1) $display("FAIL flush_cnt: got %0d want 1", sc3);
      else pass_cnt++;
`endif
      load_use_hazard();
      next_cycle();
      EX_MemRead = 1'b0;
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      settle();
      total_cnt++;
      if ({st3, bu3} !== 2'b00) $display("FAIL rst_hold_t2: got %b want 00", {st3, bu3});
      else pass_cnt++;
`ifdef HAZARD_PERF_CNT_EN
      total_cnt++;
      if (sc3 !== 32'd0) $display("FAIL rst_hold_cnt: got %0d want 0", sc3);
      else pass_cnt++;
`endif
   endtask

   function automatic logic [1:0] ref_fwd(input logic [4:0] src);
      if (MEM_RegWrite && MEM_Rd != 5'd31 && MEM_Rd == src) return 2'b10;
      if (WB_RegWrite && WB_Rd != 5'd31 && WB_Rd == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [4:0] pick_reg();
      int r;
      r = $urandom_range(0, 4);
      return (r == 4) ? 5'd31 : 5'(r);
   endfunction

   task automatic test_random;
      int rem1, rem3;
      int cnt1, cnt3;
      logic haz, e1, e3;
      logic [1:0] efa, efb;
      do_reset();
      rem1 = 0; rem3 = 0; cnt1 = 0; cnt3 = 0;
      for (int i = 0; i < 10000; i++) begin
         reset        = ($urandom_range(0, 99) == 0);
         Flush        = ($urandom_range(0, 9) == 0);
         EX_MemRead   = ($urandom_range(0, 9) < 4);
         ID_UseRn     = $urandom_range(0, 1) != 0;
         ID_UseRm     = $urandom_range(0, 1) != 0;
         MEM_RegWrite = $urandom_range(0, 1) != 0;
         WB_RegWrite  = $urandom_range(0, 1) != 0;
         ID_Rn = pick_reg(); ID_Rm = pick_reg(); EX_Rn = pick_reg(); EX_Rm = pick_reg();
         EX_Rd = pick_reg(); MEM_Rd = pick_reg(); WB_Rd = pick_reg();
         settle();
         haz = EX_MemRead && EX_Rd != 5'd31 &&
               ((ID_UseRn && EX_Rd == ID_Rn) || (ID_UseRm && EX_Rd == ID_Rm));
         e1  = Flush ? 1'b0 : (rem1 > 0 ? 1'b1 : haz);
         e3  = Flush ? 1'b0 : (rem3 > 0 ? 1'b1 : haz);
         efa = ref_fwd(EX_Rn);
         efb = ref_fwd(EX_Rm);
         total_cnt++;
         if ({fa1, fb1, st1, bu1, fa3, fb3, st3, bu3} !== {efa, efb, e1, e1, efa, efb, e3, e3})
            $display("FAIL random cycle %0d: got %b want %b", i,
                     {fa1, fb1, st1, bu1, fa3, fb3, st3, bu3}, {efa, efb, e1, e1, efa, efb, e3, e3});
         else pass_cnt++;
`ifdef HAZARD_PERF_CNT_EN
         total_cnt++;
         if (sc1 !== 32'(cnt1) || sc3 !== 32'(cnt3))
            $display("FAIL random_cnt cycle %0d: got %0d/%0d want %0d/%0d", i, sc1, sc3, cnt1, cnt3);
         else pass_cnt++;
`endif
         @(posedge clk);
         if (reset) begin
            rem1 = 0; rem3 = 0; cnt1 = 0; cnt3 = 0;
         end else begin
            cnt1 += int'(e1);
            cnt3 += int'(e3);
            if (Flush) rem1 = 0;
            else if (rem1 > 0) rem1--;
            if (Flush) rem3 = 0;
            else if (rem3 > 0) rem3--;
            else if (haz) rem3 = 2;
         end
         #1;
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_forward_priority();
      test_zero_reg();
      test_load_use_lat1();
      test_load_use_lat3();
      test_flush_and_reset_in_hold();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
